// File: rtl/cp0_reg_pkg.sv
// CP0 shared definitions: register numbers, exception codes, ExcCode values,
// reset constants and the exception-type decoder used by cp0_reg.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT = 5'd0;
  localparam logic [4:0] EXCCODE_SYS = 5'd8;
  localparam logic [4:0] EXCCODE_RI  = 5'd10;
  localparam logic [4:0] EXCCODE_OV  = 5'd12;
  localparam logic [4:0] EXCCODE_TR  = 5'd13;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;
  localparam logic [31:0] PRID_VAL   = 32'h004c_0102;

  // Cause bits software may write: IP[1:0], IV, WP
  localparam logic [31:0] CAUSE_WMASK = 32'h00c0_0300;

  typedef struct packed {
    logic       take;
    logic       is_int;
    logic       eret;
    logic [4:0] code;
  } exc_dec_t;

  function automatic exc_dec_t exc_decode(input logic [31:0] t);
    exc_dec_t d;
    d = '0;
    case (t)
      EXC_INT: begin
        d.take   = 1'b1;
        d.is_int = 1'b1;
        d.code   = EXCCODE_INT;
      end
      EXC_SYSCALL: begin
        d.take = 1'b1;
        d.code = EXCCODE_SYS;
      end
      EXC_RI: begin
        d.take = 1'b1;
        d.code = EXCCODE_RI;
      end
      EXC_OV: begin
        d.take = 1'b1;
        d.code = EXCCODE_OV;
      end
      EXC_TRAP: begin
        d.take = 1'b1;
        d.code = EXCCODE_TR;
      end
      EXC_ERET: d.eret = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky timer interrupt.
// Ports: clk, rst_n, mtc0 write (we_i/waddr_i/data_i), count_o, compare_o, timer_int_o.
module cp0_timer
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (compare_q != '0 && count_q == compare_q)
      timer_int_d = 1'b1;
    if (we_i) begin
      unique case (1'b1)
        waddr_i == CP0_REG_COUNT: count_d = data_i;
        waddr_i == CP0_REG_COMPARE: begin
          compare_d   = data_i;
          // rewriting Compare acknowledges the interrupt
          timer_int_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Status/Cause/EPC, exception entry/eret, mfc0 read port.
// Ports: clk, rst_n, mtc0 write, mfc0 read, int_i, mem-stage exception info, register outputs.
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excep_type_i,
  input  logic [31:0] curr_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  exc_dec_t    exc;

  cp0_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .data_i      (data_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int_o)
  );

  assign exc = exc_decode(excep_type_i);

  // mtc0 first, then the exception overlays only the fields it owns
  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    if (we_i) begin
      unique case (1'b1)
        waddr_i == CP0_REG_STATUS: status_d = data_i;
        waddr_i == CP0_REG_CAUSE:
          cause_d = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        waddr_i == CP0_REG_EPC: epc_d = data_i;
        default: ;
      endcase
    end
    cause_d[15:10] = int_i;
    if (exc.take) begin
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc.code;
      // nested non-interrupt exceptions keep the original EPC/BD
      if (exc.is_int || !status_q[1]) begin
        epc_d       = is_in_delayslot_i ? curr_inst_addr_i - 32'd4
                                        : curr_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
    end else if (exc.eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    data_o = '0;
    if (rst_n) begin
      unique case (1'b1)
        raddr_i == CP0_REG_COUNT:   data_o = count_o;
        raddr_i == CP0_REG_COMPARE: data_o = compare_o;
        raddr_i == CP0_REG_STATUS:  data_o = status_q;
        raddr_i == CP0_REG_CAUSE:   data_o = cause_q;
        raddr_i == CP0_REG_EPC:     data_o = epc_q;
        raddr_i == CP0_REG_PRID:    data_o = PRID_VAL;
        raddr_i == CP0_REG_CONFIG:  data_o = CONFIG_VAL;
        default: data_o = '0;
      endcase
    end
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_VAL;
  assign prid_o   = PRID_VAL;

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_cp0_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [5:0]  int_i;
  logic [31:0] excep;
  logic [31:0] pc;
  logic        ds;
  logic [31:0] data_o, count_o, compare_o, status_o;
  logic [31:0] cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  localparam logic [31:0] PRID = 32'h004C0102;
  localparam logic [31:0] CFG  = 32'h00008000;

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .we_i              (we),
    .waddr_i           (waddr),
    .data_i            (wdata),
    .raddr_i           (raddr),
    .int_i             (int_i),
    .excep_type_i      (excep),
    .curr_inst_addr_i  (pc),
    .is_in_delayslot_i (ds),
    .data_o            (data_o),
    .count_o           (count_o),
    .compare_o         (compare_o),
    .status_o          (status_o),
    .cause_o           (cause_o),
    .epc_o             (epc_o),
    .config_o          (config_o),
    .prid_o            (prid_o),
    .timer_int_o       (timer_int_o)
  );

  task automatic model_step();
    logic [31:0] nc, ncmp, ns, nca, ne;
    logic        nt, ex;
    logic [4:0]  ec;
    if (!rst_n) begin
      m_count = 0; m_compare = 0; m_status = 32'h10000000;
      m_cause = 0; m_epc = 0; m_timer = 0;
    end else begin
      nc = m_count + 1;
      ncmp = m_compare;
      nt = m_timer | (m_compare != 0 && m_count == m_compare);
      ns = m_status; nca = m_cause; ne = m_epc;
      if (we) begin
        if (waddr == 9) nc = wdata;
        if (waddr == 11) begin ncmp = wdata; nt = 0; end
        if (waddr == 12) ns = wdata;
        if (waddr == 13)
          nca = (nca & ~32'h00C00300) | (wdata & 32'h00C00300);
        if (waddr == 14) ne = wdata;
      end
      nca[15:10] = int_i;
      ex = 1; ec = 0;
      case (excep)
        32'h1: ec = 0;
        32'h8: ec = 8;
        32'ha: ec = 10;
        32'hc: ec = 12;
        32'hd: ec = 13;
        default: ex = 0;
      endcase
      if (ex) begin
        ns[1] = 1;
        nca[6:2] = ec;
        if (excep == 32'h1 || m_status[1] == 0) begin
          ne = ds ? pc - 4 : pc;
          nca[31] = ds;
        end
      end else if (excep == 32'he) begin
        ns[1] = 0;
      end
      m_count = nc; m_compare = ncmp; m_status = ns;
      m_cause = nca; m_epc = ne; m_timer = nt;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!rst_n) return 0;
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
      5'd16: return CFG;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; excep = 0;
    pc = 0; ds = 0; int_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; we = 1; waddr = 12; wdata = $urandom;
    excep = 32'h1; pc = 32'h40; raddr = 12; int_i = 6'h3f;
    tick(); tick();
    checks++; if (count_o !== 0) begin failures++;
      $display("FAIL rst_count got=%h exp=0", count_o); end
    checks++; if (compare_o !== 0) begin failures++;
      $display("FAIL rst_compare got=%h exp=0", compare_o); end
    checks++; if (status_o !== 32'h10000000) begin failures++;
      $display("FAIL rst_status got=%h exp=10000000", status_o); end
    checks++; if (cause_o !== 0 || epc_o !== 0) begin failures++;
      $display("FAIL rst_cause_epc got=%h/%h exp=0/0", cause_o, epc_o); end
    checks++; if (config_o !== CFG || prid_o !== PRID) begin failures++;
      $display("FAIL rst_cfg_prid got=%h/%h exp=%h/%h",
               config_o, prid_o, CFG, PRID); end
    checks++; if (timer_int_o !== 0) begin failures++;
      $display("FAIL rst_timer got=%b exp=0", timer_int_o); end
    checks++; if (data_o !== 0) begin failures++;
      $display("FAIL rst_data_o got=%h exp=0", data_o); end
    idle(); rst_n = 1;
    repeat (10) tick();
    checks++; if (count_o !== 32'd10) begin failures++;
      $display("FAIL count_10 got=%h exp=0000000a", count_o); end
    checks++; if (status_o !== 32'h10000000 || prid_o !== PRID) begin
      failures++;
      $display("FAIL run_status_prid got=%h/%h", status_o, prid_o); end
    checks++; if (timer_int_o !== 0) begin failures++;
      $display("FAIL run_timer got=%b exp=0", timer_int_o); end
    checks++; if (data_o !== 32'h10000000) begin failures++;
      $display("FAIL read_status got=%h exp=10000000", data_o); end
  endtask

  task automatic test_timer();
    we = 1; waddr = 11; wdata = 32'h20;
    tick(); idle();
    checks++; if (compare_o !== 32'h20 || timer_int_o !== 0) begin
      failures++;
      $display("FAIL cmp_write got=%h/%b exp=20/0", compare_o, timer_int_o); end
    for (int i = 0; i < 64; i++) begin
      if (count_o == 32'h20) break;
      tick();
    end
    checks++; if (count_o !== 32'h20 || timer_int_o !== 0) begin
      failures++;
      $display("FAIL count_hit got=%h/%b exp=20/0", count_o, timer_int_o); end
    tick();
    checks++; if (timer_int_o !== 1) begin failures++;
      $display("FAIL timer_rise got=%b exp=1", timer_int_o); end
    tick();
    checks++; if (timer_int_o !== 1) begin failures++;
      $display("FAIL timer_sticky got=%b exp=1", timer_int_o); end
    we = 1; waddr = 11; wdata = 32'h40;
    tick(); idle();
    checks++; if (timer_int_o !== 0 || compare_o !== 32'h40) begin
      failures++;
      $display("FAIL timer_clear got=%b/%h exp=0/40", timer_int_o, compare_o); end
  endtask

  task automatic test_exceptions();
    excep = 32'h8; pc = 32'h100; ds = 1;
    tick(); idle();
    checks++; if (epc_o !== 32'hFC) begin failures++;
      $display("FAIL sys_epc got=%h exp=000000fc", epc_o); end
    checks++; if (cause_o[31] !== 1 || cause_o[6:2] !== 5'd8) begin
      failures++;
      $display("FAIL sys_cause got=%h exp=bd1 code8", cause_o); end
    checks++; if (status_o[1] !== 1) begin failures++;
      $display("FAIL sys_exl got=%h exp=exl1", status_o); end
    excep = 32'hc; pc = 32'h200; ds = 0;
    tick(); idle();
    checks++; if (epc_o !== 32'hFC || cause_o[31] !== 1) begin failures++;
      $display("FAIL nested_epc got=%h/%h exp=fc/bd1", epc_o, cause_o); end
    checks++; if (cause_o[6:2] !== 5'd12) begin failures++;
      $display("FAIL nested_code got=%h exp=12", cause_o[6:2]); end
    excep = 32'he;
    tick(); idle();
    checks++; if (status_o !== 32'h10000000) begin failures++;
      $display("FAIL eret got=%h exp=10000000", status_o); end
  endtask

  task automatic test_same_cycle();
    we = 1; waddr = 12; wdata = 32'h0000FF01;
    excep = 32'h1; pc = 32'h300; ds = 0;
    tick(); idle();
    checks++; if (status_o !== 32'h0000FF03) begin failures++;
      $display("FAIL mtc0_int_status got=%h exp=0000ff03", status_o); end
    checks++; if (epc_o !== 32'h300) begin failures++;
      $display("FAIL mtc0_int_epc got=%h exp=00000300", epc_o); end
  endtask

  task automatic test_cause_prid_reset();
    int_i = 0; we = 1; waddr = 13; wdata = 32'hFFFFFFFF;
    tick(); idle();
    checks++; if (cause_o !== 32'h00C00300) begin failures++;
      $display("FAIL cause_mask got=%h exp=00c00300", cause_o); end
    we = 1; waddr = 15; wdata = 0;
    tick();
    waddr = 16;
    tick(); idle();
    checks++; if (prid_o !== PRID || config_o !== CFG) begin failures++;
      $display("FAIL ro_write got=%h/%h", prid_o, config_o); end
    // EXL=1 syscall with same-cycle EPC write: EPC keeps the mtc0 value
    we = 1; waddr = 14; wdata = 32'h1234; excep = 32'h8; pc = 32'h500;
    tick(); idle();
    checks++; if (epc_o !== 32'h1234 || cause_o[6:2] !== 5'd8) begin
      failures++;
      $display("FAIL exl_epc_write got=%h/%h exp=1234/8", epc_o, cause_o); end
    rst_n = 0; we = 1; waddr = 9; wdata = 32'h55; excep = 32'h8;
    pc = 32'h600; int_i = 6'h2a; raddr = 9;
    tick();
    checks++; if (count_o !== 0 || compare_o !== 0 || cause_o !== 0 ||
                  epc_o !== 0 || status_o !== 32'h10000000 ||
                  timer_int_o !== 0 || data_o !== 0) begin
      failures++;
      $display("FAIL mid_reset got=%h %h %h %h %h %b %h", count_o, compare_o,
               cause_o, epc_o, status_o, timer_int_o, data_o); end
    idle(); rst_n = 1;
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: waddr = 9;  1: waddr = 11; 2: waddr = 12; 3: waddr = 13;
        4: waddr = 14; 5: waddr = 15; 6: waddr = 16;
        default: waddr = 5'($urandom);
      endcase
      wdata = $urandom;
      if (waddr == 11 && $urandom_range(0, 1) == 1)
        wdata = m_count + $urandom_range(1, 6);
      sel = $urandom_range(0, 10);
      case (sel)
        0: excep = 32'h1; 1: excep = 32'h8; 2: excep = 32'ha;
        3: excep = 32'hc; 4: excep = 32'hd; 5: excep = 32'he;
        6: excep = $urandom;
        default: excep = 0;
      endcase
      int_i = 6'($urandom);
      pc = $urandom & 32'hFFFFFFFC;
      ds = 1'($urandom);
      raddr = 5'($urandom);
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
      checks++; if (count_o !== m_count) begin failures++;
        $display("FAIL rnd_count i=%0d got=%h exp=%h", i, count_o, m_count); end
      checks++; if (compare_o !== m_compare) begin failures++;
        $display("FAIL rnd_compare i=%0d got=%h exp=%h", i, compare_o, m_compare); end
      checks++; if (status_o !== m_status) begin failures++;
        $display("FAIL rnd_status i=%0d got=%h exp=%h", i, status_o, m_status); end
      checks++; if (cause_o !== m_cause) begin failures++;
        $display("FAIL rnd_cause i=%0d got=%h exp=%h", i, cause_o, m_cause); end
      checks++; if (epc_o !== m_epc) begin failures++;
        $display("FAIL rnd_epc i=%0d got=%h exp=%h", i, epc_o, m_epc); end
      checks++; if (timer_int_o !== m_timer) begin failures++;
        $display("FAIL rnd_timer i=%0d got=%b exp=%b", i, timer_int_o, m_timer); end
      checks++; if (prid_o !== PRID || config_o !== CFG) begin failures++;
        $display("FAIL rnd_ro i=%0d got=%h/%h", i, prid_o, config_o); end
      checks++; if (data_o !== model_read(raddr)) begin failures++;
        $display("FAIL rnd_read i=%0d a=%0d got=%h exp=%h",
                 i, raddr, data_o, model_read(raddr)); end
      rst_n = 1;
    end
    idle();
  endtask

  initial begin
    m_count = 0; m_compare = 0; m_status = 0;
    m_cause = 0; m_epc = 0; m_timer = 0;
    rst_n = 0; raddr = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_timer();
    test_exceptions();
    test_same_cycle();
    test_cause_prid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- we_i  in  1  software (mtc0) write enable, from wb stage
- waddr_i  in  5  write register number
- data_i  in  32  write data
- raddr_i  in  5  read register number (mfc0, ex stage)
- int_i  in  6  external hardware interrupt lines
- excep_type_i  in  32  final exception code from mem stage
- curr_inst_addr_i  in  32  PC of the mem-stage instruction
- is_in_delayslot_i  in  1  mem-stage instruction is in a delay slot
- data_o  out  32  read data
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  register contents
- timer_int_o  out  1  timer interrupt request

REQ-002 SHALL decode registers as: Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16.

REQ-003 SHALL decode excep_type_i codes as: 0x1 interrupt, 0x8 syscall, 0xa reserved instruction, 0xc overflow, 0xd trap, 0xe eret, 0x0 none.

Function
REQ-004 SHALL increment Count by 1 every cycle out of reset, wrapping 0xFFFFFFFF->0; an mtc0 write to Count in the same cycle SHALL win over the increment.

REQ-005 SHALL set timer_int_o (sticky) when Compare!=0 and Count==Compare; an mtc0 write to Compare SHALL clear timer_int_o in the same edge.

REQ-006 SHALL load Cause[15:10] from int_i every cycle.

REQ-007 mtc0 writes SHALL update fields as follows:
- Status, Count, Compare, EPC: full 32 bits
- Cause: bits [9:8], 22, 23 only
- PRId, Config: read-only, write ignored

REQ-008 data_o SHALL be combinational from raddr_i using the current registered value; unmapped numbers SHALL return 0.

REQ-009 On codes 0x1, 0x8, 0xa, 0xc, 0xd the block SHALL set Status[1] (EXL)=1 and write Cause[6:2] with ExcCode 0, 8, 10, 12, 13 respectively.

REQ-010 Within the REQ-009 exceptions, EPC/BD update SHALL depend on prior EXL:
- Interrupts always update EPC/BD.
- Other exceptions update EPC/BD only when prior EXL=0.
- Update values: delay slot -> EPC=curr_inst_addr_i-4, Cause[31]=1; otherwise EPC=curr_inst_addr_i, Cause[31]=0.

REQ-011 On code 0xe the block SHALL clear Status[1] only.

REQ-012 When an mtc0 write and an exception occur in the same cycle, exception-updated fields SHALL take the exception value and all other written fields SHALL take the mtc0 value.

REQ-013 Unknown nonzero codes SHALL leave all registers except Count/Cause[15:10] unchanged.

REQ-014 All register updates SHALL take effect at the clock edge: one-cycle latency to outputs.

Reset
REQ-015 On rst_n=0 at a clock edge, all registers SHALL take these values, overriding any same-cycle write or exception:
- Count, Compare, Cause, EPC = 0
- Status = 0x10000000
- Config = 0x00008000
- PRId = 0x004C0102
- timer_int_o = 0

REQ-016 data_o SHALL be 0 while rst_n=0.

Structure
REQ-017 CP0 register numbers (CP0_REG_*), exception-type codes and ExcCode values SHALL live in shared defines.v.

REQ-018 Count/Compare/timer_int logic SHALL be a sub-module cp0_timer; all other logic stays in cp0_reg.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then run 10 cycles -> count_o=10, status_o=0x10000000, prid_o=0x004C0102, timer_int_o=0.
- mtc0 Compare=0x20 -> timer_int_o rises the edge after count_o==0x20; mtc0 Compare=0x40 -> timer_int_o=0 next cycle.
- excep_type_i=0x8, curr_inst_addr_i=0x100, delay slot=1, EXL=0 -> epc_o=0xFC, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
- With EXL=1, excep_type_i=0xc, addr=0x200 -> EPC unchanged, cause_o[6:2]=12; then excep_type_i=0xe -> status_o[1]=0.
- Same cycle: mtc0 Status=0x0000FF01 and excep_type_i=0x1 -> status_o=0x0000FF03.
- mtc0 Cause=0xFFFFFFFF with int_i=0 -> cause_o=0x00C00300; mtc0 PRId=0 -> prid_o unchanged; rst_n=0 mid-sequence -> all reset values next edge.
